// File: rtl/mem_arb_pkg.sv
// Shared bounds and round-robin helper for the MEM-port arbiter.
package mem_arb_pkg;

   localparam int MAX_NUM_REQ           = 8;
   localparam int MAX_OUTSTANDING_LIMIT = 8;

   // Index following idx in a ring of num entries.
   function automatic int rr_next(input int idx, input int num);
      return (idx + 1 >= num) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mem_arb_idx_fifo.sv
// Small synchronous FIFO holding the requester index of each in-flight transaction.
module mem_arb_idx_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & (count_reg != '0);
   assign count   = count_reg;
   assign head    = mem_reg[rd_ptr_reg];

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one MEM slave port among NUM_REQ requesters,
// with in-order response routing back to the issuing requester.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int MEM_ADDR_WIDTH  = 32,
   parameter int MEM_DATA_WIDTH  = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                         clk_i,
   input  logic                                         rst_i,
   input  logic [NUM_REQ-1:0]                           s_mem_req,
   input  logic [NUM_REQ-1:0][MEM_ADDR_WIDTH-1:0]       s_mem_addr,
   input  logic [NUM_REQ-1:0]                           s_mem_we,
   input  logic [NUM_REQ-1:0][MEM_DATA_WIDTH-1:0]       s_mem_wdata,
   input  logic [NUM_REQ-1:0][MEM_DATA_WIDTH/8-1:0]     s_mem_be,
   output logic [NUM_REQ-1:0]                           s_mem_gnt,
   output logic [NUM_REQ-1:0]                           s_mem_valid,
   output logic [NUM_REQ-1:0][MEM_DATA_WIDTH-1:0]       s_mem_rdata,
   output logic [NUM_REQ-1:0]                           s_mem_error,
   output logic                                         m_mem_req,
   output logic [MEM_ADDR_WIDTH-1:0]                    m_mem_addr,
   output logic                                         m_mem_we,
   output logic [MEM_DATA_WIDTH-1:0]                    m_mem_wdata,
   output logic [MEM_DATA_WIDTH/8-1:0]                  m_mem_be,
   input  logic                                         m_mem_gnt,
   input  logic                                         m_mem_valid,
   input  logic [MEM_DATA_WIDTH-1:0]                    m_mem_rdata,
   input  logic                                         m_mem_error,
   output logic                                         unexp_rsp_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ ||
       MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAX_OUTSTANDING_LIMIT) begin : g_bad_params
      $error("mem_port_arbiter: NUM_REQ or MAX_OUTSTANDING out of range");
   end

   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic             locked_reg, locked_next;
   logic [IDX_W-1:0] lock_idx_reg, lock_idx_next;
   logic             unexp_reg, unexp_next;

   logic [IDX_W-1:0] search_sel, sel;
   logic [IDX_W-1:0] fifo_head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             handshake, rsp_ok;

   // First requesting index at or after rr_ptr, wrapping around the ring.
   always_comb begin
      int  cand;
      logic found;
      search_sel = rr_ptr_reg;
      found      = 1'b0;
      cand       = int'(rr_ptr_reg);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && s_mem_req[IDX_W'(cand)]) begin
            search_sel = IDX_W'(cand);
            found      = 1'b1;
         end
         cand = rr_next(cand, NUM_REQ);
      end
   end

   assign sel       = locked_reg ? lock_idx_reg : search_sel;
   assign m_mem_req = s_mem_req[sel] & ~fifo_full;
   assign handshake = m_mem_req & m_mem_gnt;
   assign rsp_ok    = m_mem_valid & (fifo_count != '0);

   assign m_mem_addr  = m_mem_req ? s_mem_addr[sel]  : '0;
   assign m_mem_we    = m_mem_req ? s_mem_we[sel]    : 1'b0;
   assign m_mem_wdata = m_mem_req ? s_mem_wdata[sel] : '0;
   assign m_mem_be    = m_mem_req ? s_mem_be[sel]    : '0;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign s_mem_gnt[gi]   = handshake & (sel == IDX_W'(gi));
      assign s_mem_valid[gi] = rsp_ok & (fifo_head == IDX_W'(gi));
      assign s_mem_error[gi] = rsp_ok & (fifo_head == IDX_W'(gi)) & m_mem_error;
      assign s_mem_rdata[gi] = rsp_ok ? m_mem_rdata : '0;
   end

   mem_arb_idx_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDX_W),
      .CNT_W (CNT_W)
   ) u_idx_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (handshake),
      .push_data (sel),
      .pop       (rsp_ok),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full)
   );

   // A request left ungranted pins the selection until the downstream grants it.
   always_comb begin
      rr_ptr_next   = rr_ptr_reg;
      locked_next   = locked_reg;
      lock_idx_next = lock_idx_reg;
      unexp_next    = unexp_reg | (m_mem_valid & (fifo_count == '0));
      if (handshake) begin
         rr_ptr_next = IDX_W'(rr_next(int'(sel), NUM_REQ));
         locked_next = 1'b0;
      end else if (m_mem_req) begin
         locked_next   = 1'b1;
         lock_idx_next = sel;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_reg   <= '0;
         locked_reg   <= 1'b0;
         lock_idx_reg <= '0;
         unexp_reg    <= 1'b0;
      end else begin
         rr_ptr_reg   <= rr_ptr_next;
         locked_reg   <= locked_next;
         lock_idx_reg <= lock_idx_next;
         unexp_reg    <= unexp_next;
      end
   end

   assign unexp_rsp_o = unexp_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus round-robin and reset sequences.
module tb_mem_port_arbiter;

   localparam int NR = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 2;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NR-1:0]          s_req, s_we, s_gnt, s_valid, s_err;
   logic [NR-1:0][AW-1:0]  s_addr;
   logic [NR-1:0][DW-1:0]  s_wdata, s_rdata;
   logic [NR-1:0][BW-1:0]  s_be;
   logic                   m_req, m_we, m_gnt, m_valid, m_err, unexp;
   logic [AW-1:0]          m_addr;
   logic [DW-1:0]          m_wdata, m_rdata;
   logic [BW-1:0]          m_be;

   mem_port_arbiter #(
      .NUM_REQ(NR), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .s_mem_req(s_req), .s_mem_addr(s_addr), .s_mem_we(s_we),
      .s_mem_wdata(s_wdata), .s_mem_be(s_be),
      .s_mem_gnt(s_gnt), .s_mem_valid(s_valid), .s_mem_rdata(s_rdata), .s_mem_error(s_err),
      .m_mem_req(m_req), .m_mem_addr(m_addr), .m_mem_we(m_we),
      .m_mem_wdata(m_wdata), .m_mem_be(m_be),
      .m_mem_gnt(m_gnt), .m_mem_valid(m_valid), .m_mem_rdata(m_rdata), .m_mem_error(m_err),
      .unexp_rsp_o(unexp)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic        gnt;
      logic        valid;
      logic        err;
      logic [31:0] rdata;
      logic        mreq;
      int          sel;
      logic [1:0]  sgnt;
      logic [1:0]  svalid;
      logic [1:0]  serr;
      logic [31:0] srdata;
      logic        unexp;
   } vec_t;

   vec_t vecs[18];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs, check outputs mid-cycle, then let the clock edge consume them.
   task automatic run_vec(input vec_t v, input string tag);
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [BW-1:0] eb;
      logic          ew;
      rst     = v.rst;
      s_req   = v.req;
      m_gnt   = v.gnt;
      m_valid = v.valid;
      m_err   = v.err;
      m_rdata = v.rdata;
      #2;
      ea = '0; ed = '0; eb = '0; ew = 1'b0;
      if (v.sel >= 0) begin
         ea = s_addr[v.sel]; ed = s_wdata[v.sel]; eb = s_be[v.sel]; ew = s_we[v.sel];
      end
      chk({tag, " m_req"},   32'(m_req),      32'(v.mreq));
      chk({tag, " m_addr"},  m_addr,          ea);
      chk({tag, " m_we"},    32'(m_we),       32'(ew));
      chk({tag, " m_wdata"}, m_wdata,         ed);
      chk({tag, " m_be"},    32'(m_be),       32'(eb));
      chk({tag, " s_gnt"},   32'(s_gnt),      32'(v.sgnt));
      chk({tag, " s_valid"}, 32'(s_valid),    32'(v.svalid));
      chk({tag, " s_error"}, 32'(s_err),      32'(v.serr));
      chk({tag, " rdata0"},  s_rdata[0],      v.srdata);
      chk({tag, " rdata1"},  s_rdata[1],      v.srdata);
      chk({tag, " unexp"},   32'(unexp),      32'(v.unexp));
      $display("%s: req=%b gnt=%b valid=%b -> m_req=%b addr=%h s_gnt=%b s_valid=%b s_err=%b unexp=%b",
               tag, v.req, v.gnt, v.valid, m_req, m_addr, s_gnt, s_valid, s_err, unexp);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic g, input logic vl,
                               input logic e, input logic [31:0] rd, input logic mr, input int sl,
                               input logic [1:0] sg, input logic [1:0] sv, input logic [1:0] se,
                               input logic [31:0] srd, input logic ux);
      vec_t v;
      v.rst = r; v.req = rq; v.gnt = g; v.valid = vl; v.err = e; v.rdata = rd;
      v.mreq = mr; v.sel = sl; v.sgnt = sg; v.svalid = sv; v.serr = se; v.srdata = srd; v.unexp = ux;
      return v;
   endfunction

   initial begin
      int   outst;
      int   exp_g;
      int   pend_idx[$];
      int   pend_time[$];
      vec_t v;

      s_addr[0]  = 32'h0000_0100;  s_addr[1]  = 32'h0000_0200;
      s_wdata[0] = 32'h1111_1111;  s_wdata[1] = 32'h2222_2222;
      s_be[0]    = 4'hF;           s_be[1]    = 4'h3;
      s_we       = 2'b10;
      rst = 1'b1; s_req = '0; m_gnt = 0; m_valid = 0; m_err = 0; m_rdata = '0;
      repeat (2) @(posedge clk);
      #1;

      //            rst rq    g  vl e  rdata         mreq sel sgnt   svalid serr   srdata        unexp
      vecs[0]  = mk(1, 2'b00, 0, 0, 0, 32'h0,        0,  -1, 2'b00, 2'b00, 2'b00, 32'h0,        0);
      vecs[1]  = mk(0, 2'b01, 0, 0, 0, 32'h0,        1,   0, 2'b00, 2'b00, 2'b00, 32'h0,        0);
      vecs[2]  = mk(0, 2'b11, 0, 0, 0, 32'h0,        1,   0, 2'b00, 2'b00, 2'b00, 32'h0,        0);
      vecs[3]  = mk(0, 2'b11, 0, 0, 0, 32'h0,        1,   0, 2'b00, 2'b00, 2'b00, 32'h0,        0);
      vecs[4]  = mk(0, 2'b11, 1, 0, 0, 32'h0,        1,   0, 2'b01, 2'b00, 2'b00, 32'h0,        0);
      vecs[5]  = mk(0, 2'b11, 1, 0, 0, 32'h0,        1,   1, 2'b10, 2'b00, 2'b00, 32'h0,        0);
      vecs[6]  = mk(0, 2'b11, 1, 0, 0, 32'h0,        0,  -1, 2'b00, 2'b00, 2'b00, 32'h0,        0);
      vecs[7]  = mk(0, 2'b11, 1, 1, 0, 32'h12345678, 0,  -1, 2'b00, 2'b01, 2'b00, 32'h12345678, 0);
      vecs[8]  = mk(0, 2'b11, 1, 1, 1, 32'hDEADBEEF, 1,   0, 2'b01, 2'b10, 2'b10, 32'hDEADBEEF, 0);
      vecs[9]  = mk(0, 2'b00, 0, 1, 0, 32'h0000CAFE, 0,  -1, 2'b00, 2'b01, 2'b00, 32'h0000CAFE, 0);
      vecs[10] = mk(0, 2'b00, 0, 1, 0, 32'h00000055, 0,  -1, 2'b00, 2'b00, 2'b00, 32'h0,        0);
      vecs[11] = mk(0, 2'b00, 0, 0, 0, 32'h0,        0,  -1, 2'b00, 2'b00, 2'b00, 32'h0,        1);
      vecs[12] = mk(0, 2'b10, 0, 0, 0, 32'h0,        1,   1, 2'b00, 2'b00, 2'b00, 32'h0,        1);
      vecs[13] = mk(0, 2'b01, 1, 0, 0, 32'h0,        0,  -1, 2'b00, 2'b00, 2'b00, 32'h0,        1);
      vecs[14] = mk(0, 2'b11, 1, 0, 0, 32'h0,        1,   1, 2'b10, 2'b00, 2'b00, 32'h0,        1);
      vecs[15] = mk(1, 2'b00, 0, 0, 0, 32'h0,        0,  -1, 2'b00, 2'b00, 2'b00, 32'h0,        1);
      vecs[16] = mk(0, 2'b00, 0, 1, 0, 32'h00000077, 0,  -1, 2'b00, 2'b00, 2'b00, 32'h0,        0);
      vecs[17] = mk(0, 2'b00, 0, 0, 0, 32'h0,        0,  -1, 2'b00, 2'b00, 2'b00, 32'h0,        1);

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Round robin under contention with responses two cycles after each grant.
      run_vec(mk(1, 2'b00, 0, 0, 0, 32'h0, 0, -1, 2'b00, 2'b00, 2'b00, 32'h0, 1), "rr_reset");
      outst = 0;
      exp_g = 0;
      for (int c = 0; c < 12; c++) begin
         logic resp;
         resp = (pend_time.size() > 0) && (pend_time[0] == c);
         v = mk(0, 2'b11, 1, resp, 0, 32'h1000 + 32'(c),
                (outst != MO), (outst != MO) ? exp_g : -1,
                (outst != MO) ? 2'(1 << exp_g) : 2'b00,
                resp ? 2'(1 << pend_idx[0]) : 2'b00, 2'b00,
                resp ? 32'h1000 + 32'(c) : 32'h0, 0);
         run_vec(v, $sformatf("rr%0d", c));
         if (resp) begin
            void'(pend_idx.pop_front());
            void'(pend_time.pop_front());
            outst--;
         end
         if (v.mreq) begin
            pend_idx.push_back(exp_g);
            pend_time.push_back(c + 2);
            outst++;
            exp_g ^= 1;
         end
      end

      // Reset while a transaction is outstanding and requester 1 holds the lock.
      run_vec(mk(1, 2'b00, 0, 0, 0, 32'h0,        0, -1, 2'b00, 2'b00, 2'b00, 32'h0, 0), "rb0");
      run_vec(mk(0, 2'b01, 1, 0, 0, 32'h0,        1,  0, 2'b01, 2'b00, 2'b00, 32'h0, 0), "rb1");
      run_vec(mk(0, 2'b10, 0, 0, 0, 32'h0,        1,  1, 2'b00, 2'b00, 2'b00, 32'h0, 0), "rb2");
      run_vec(mk(0, 2'b11, 0, 0, 0, 32'h0,        1,  1, 2'b00, 2'b00, 2'b00, 32'h0, 0), "rb3");
      run_vec(mk(1, 2'b00, 0, 0, 0, 32'h0,        0, -1, 2'b00, 2'b00, 2'b00, 32'h0, 0), "rb4");
      run_vec(mk(0, 2'b11, 0, 0, 0, 32'h0,        1,  0, 2'b00, 2'b00, 2'b00, 32'h0, 0), "rb5");
      run_vec(mk(0, 2'b00, 0, 1, 0, 32'hBEEF0001, 0, -1, 2'b00, 2'b00, 2'b00, 32'h0, 0), "rb6");
      run_vec(mk(0, 2'b00, 0, 1, 1, 32'hBEEF0002, 0, -1, 2'b00, 2'b00, 2'b00, 32'h0, 1), "rb7");
      run_vec(mk(0, 2'b00, 0, 0, 0, 32'h0,        0, -1, 2'b00, 2'b00, 2'b00, 32'h0, 1), "rb8");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one MEM-protocol slave port, typically the MEM side of the AXI-from-MEM bridge wrapper, between `NUM_REQ` MEM-protocol requesters such as a core's instruction and data ports and a debug module. It arbitrates requests and holds the selection stable until the downstream port grants. It also records the granted requester of every in-flight transaction, so that in-order downstream responses return to the requester that issued them.

## Interface
- `NUM_REQ`, 2: number of upstream requesters (2..8).
- `MEM_ADDR_WIDTH`, 32: address width.
- `MEM_DATA_WIDTH`, 32: data width; byte-enable width is `MEM_DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, 2: maximum number of granted transactions still awaiting a response (1..8).
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `s_mem_req`  in  NUM_REQ  per-requester request.
- `s_mem_addr`  in  NUM_REQ×MEM_ADDR_WIDTH  per-requester address.
- `s_mem_we`  in  NUM_REQ  per-requester write enable.
- `s_mem_wdata`  in  NUM_REQ×MEM_DATA_WIDTH  per-requester write data.
- `s_mem_be`  in  NUM_REQ×MEM_DATA_WIDTH/8  per-requester byte enables.
- `s_mem_gnt`  out  NUM_REQ  per-requester grant.
- `s_mem_valid`  out  NUM_REQ  per-requester response valid.
- `s_mem_rdata`  out  NUM_REQ×MEM_DATA_WIDTH  response data, broadcast to all requesters.
- `s_mem_error`  out  NUM_REQ  per-requester response error.
- `m_mem_req`, `m_mem_addr`, `m_mem_we`, `m_mem_wdata`, `m_mem_be`  out  1/AW/1/DW/DW/8  downstream request.
- `m_mem_gnt`, `m_mem_valid`, `m_mem_rdata`, `m_mem_error`  in  1/1/DW/1  downstream grant and response.
- `unexp_rsp_o`  out  1  sticky flag: a downstream response arrived with no transaction outstanding.

## Operation
- **State.** The block holds:
  - the round-robin pointer `rr_ptr`, of width `$clog2(NUM_REQ)`;
  - the lock flag `locked` and the locked index `lock_idx`;
  - an index FIFO of depth `MAX_OUTSTANDING` with count `cnt`, of width `$clog2(MAX_OUTSTANDING+1)`;
  - the sticky flag `unexp_rsp_o`.
- **Selection.**
  - If `locked` is set, `sel = lock_idx`.
  - Otherwise `sel` is the first requester with `s_mem_req` high, searching from `rr_ptr` upward with wrap-around.
- **Forwarding.**
  - `m_mem_req = s_mem_req[sel] & (cnt != MAX_OUTSTANDING)`.
  - `m_mem_addr`, `m_mem_we`, `m_mem_wdata` and `m_mem_be` carry requester `sel`'s fields while `m_mem_req` is high, and are all zero otherwise.
  - `s_mem_gnt[sel] = m_mem_gnt & m_mem_req`. All other grant bits are 0.
- **Handshake.** A handshake is `m_mem_req & m_mem_gnt`. On a handshake:
  - push `sel` into the FIFO;
  - set `rr_ptr` to `(sel+1) mod NUM_REQ`;
  - clear `locked`.
- **Lock.**
  - If `m_mem_req` is high and `m_mem_gnt` is low, set `locked` and `lock_idx = sel`. Selection cannot change until that request is granted.
  - Requesters must not drop `req` before `gnt`. If they do, the lock still holds, and `m_mem_req` follows the locked requester's `req`.
- **Response routing.**
  - When `m_mem_valid` is high and `cnt > 0`:
    - assert `s_mem_valid[head]` and `s_mem_error[head]` (the latter equal to `m_mem_error`);
    - drive `s_mem_rdata = m_mem_rdata` to all requesters;
    - pop the FIFO.
  - When `m_mem_valid` is high and `cnt == 0`: drop the response, drive no `s_mem_valid`, and set `unexp_rsp_o`.
- **Full FIFO.** When `cnt == MAX_OUTSTANDING`, `m_mem_req` is forced to 0, even if a pop occurs in the same cycle. The lock state is unchanged.
- **Simultaneous push and pop.** Both happen; `cnt` is unchanged; the FIFO ordering is preserved.
- **Responses are in order.** The downstream port returns responses in grant order; the bridge behind it uses a single AXI ID.

## Timing
- Grant path is combinational: `s_mem_req` to `m_mem_req`, and `m_mem_gnt` to `s_mem_gnt`, with zero added latency.
- Response path is combinational: `m_mem_valid` to `s_mem_valid[head]` in the same cycle.
- A response is never accepted for a request pushed in the same cycle. Downstream latency is at least 1 cycle.
- **Reset.** While `rst_i` is high at a clock edge:
  - `rr_ptr = 0`, `locked = 0`, `lock_idx = 0`, `cnt = 0`, `unexp_rsp_o = 0`.
  - With all `s_mem_req` low, every output is 0.
- **Reset mid-operation.** In-flight transactions are forgotten. Late responses for them are dropped and set `unexp_rsp_o`.
- **Fairness.** A continuously requesting requester waits at most `NUM_REQ-1` handshakes before it is granted.

## Structure
- **Package `mem_arb_pkg`:** the `MAX_NUM_REQ = 8` and `MAX_OUTSTANDING_LIMIT = 8` bounds, and a helper function that computes the round-robin next index.
- **Sub-module `mem_arb_idx_fifo`:** a synchronous FIFO parameterised by depth and width. It provides push, pop, head, count and full, and has the same clock and reset as this block.
- **Top-level RTL:** priority search, lock, forwarding mux and response demux.

## Test plan
- **Round-robin under contention.** `NUM_REQ=2`, both `req` held high, downstream `gnt` always 1, each response 2 cycles after its grant → grants alternate 0,1,0,1; each `s_mem_valid` goes to the index that was granted 2 cycles earlier.
- **Lock holds.** Requester 0 requests `addr=0x100`; `gnt` is held low for 3 cycles; requester 1 raises `req` in cycle 1 → `m_mem_addr` stays `0x100` until `gnt`; requester 1 is granted next.
- **Full FIFO.** `MAX_OUTSTANDING=2`, two grants with no response yet → `m_mem_req=0` with requests pending. After one `m_mem_valid`, `m_mem_req` rises in the following cycle.
- **Push and pop together.** With `cnt=1`, a handshake and an `m_mem_valid` in the same cycle → `cnt` stays 1, and the response goes to the older index.
- **Error routing and unexpected response.** Response with `m_mem_error=1` and `rdata=0xDEADBEEF` while requester 1 is at the FIFO head → `s_mem_error[1]=1`, `s_mem_valid[1]=1`. A further `m_mem_valid` with `cnt=0` → no `s_mem_valid`; `unexp_rsp_o` rises and stays high.
- **Reset mid-burst.** `rst_i` pulsed with `cnt=2` and a lock active → the next cycle has `cnt=0`, the lock cleared and `rr_ptr=0`; the two late responses set `unexp_rsp_o`.
